// File: rtl/cgp_pkg.sv
// Shared sizing, state encoding and scoring helper for the serial chromosome evaluator.
package cgp_pkg;

  localparam int ROW        = 2;
  localparam int COL        = 2;
  localparam int IN         = 2;
  localparam int OUT        = 1;
  localparam int GENE_W     = 16;
  localparam int LOAD_W     = 8;

  localparam int NCELL      = ROW * COL;
  localparam int CELL_SEL_W = $clog2(NCELL);
  localparam int CHROM_W    = NCELL * GENE_W + CELL_SEL_W * OUT;
  localparam int NWORDS     = (CHROM_W + LOAD_W - 1) / LOAD_W;
  localparam int NVEC       = 2 ** IN;
  localparam int TT_W       = OUT * NVEC;
  localparam int FIT_W      = $clog2(TT_W + 1);
  localparam int WCNT_W     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int SH_W       = $clog2(NWORDS * LOAD_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } eval_state_t;

  // Number of output bits that agree with the expected bits for one vector.
  function automatic logic [FIT_W-1:0] match_count(input logic [OUT-1:0] a,
                                                   input logic [OUT-1:0] b);
    logic [FIT_W-1:0] c;
    c = '0;
    for (int k = 0; k < OUT; k++) begin
      c = c + FIT_W'(a[k] ~^ b[k]);
    end
    return c;
  endfunction

endpackage

// File: rtl/chrom_slicer.sv
// Splits the held chromosome into per-cell descriptors and the output-select field.
module chrom_slicer
  import cgp_pkg::*;
(
  input  logic [CHROM_W-1:0]          i_chrom,
  output logic [NCELL*GENE_W-1:0]     o_genes,
  output logic [CELL_SEL_W*OUT-1:0]   o_osel
);

  for (genvar gi = 0; gi < ROW; gi++) begin : g_row
    for (genvar gj = 0; gj < COL; gj++) begin : g_col
      assign o_genes[GENE_W*(COL*gi+gj) +: GENE_W] = i_chrom[GENE_W*(COL*gi+gj) +: GENE_W];
    end
  end

  assign o_osel = i_chrom[CHROM_W-1:NCELL*GENE_W];

endmodule

// File: rtl/newGenetico.sv
// Combinational genetic array. Each cell descriptor:
//   [3:0] source select A, [7:4] source select B (taken modulo the source count),
//   [11:8] 2-input LUT indexed by {B,A}, [GENE_W-1:12] parity of these bits inverts the cell.
// Column 0 cells read the primary inputs; column j cells read the outputs of column j-1.
// Each circuit output picks one cell by its flat index COL*i+j.
module newGenetico #(
  parameter int ROW        = 2,
  parameter int COL        = 2,
  parameter int IN         = 2,
  parameter int OUT        = 1,
  parameter int GENE_W     = 16,
  parameter int CELL_SEL_W = $clog2(ROW * COL)
) (
  input  logic [IN-1:0]              i_in,
  input  logic [ROW*COL*GENE_W-1:0]  i_genes,
  input  logic [CELL_SEL_W*OUT-1:0]  i_osel,
  output logic [OUT-1:0]             o_out
);

  localparam int NCELL = ROW * COL;

  logic [NCELL-1:0] w_cell;

  for (genvar gi = 0; gi < ROW; gi++) begin : g_row
    for (genvar gj = 0; gj < COL; gj++) begin : g_col
      localparam int NSRC  = (gj == 0) ? IN : ROW;
      localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;

      logic [GENE_W-1:0] w_gene;
      logic [NSRC-1:0]   w_src;
      logic [SRC_W-1:0]  w_ia;
      logic [SRC_W-1:0]  w_ib;
      logic [3:0]        w_lut;
      logic              w_out;

      assign w_gene = i_genes[GENE_W*(COL*gi+gj) +: GENE_W];

      if (gj == 0) begin : g_pi
        assign w_src = i_in;
      end else begin : g_prev
        for (genvar gr = 0; gr < ROW; gr++) begin : g_src
          assign w_src[gr] = g_row[gr].g_col[gj-1].w_out;
        end
      end

      assign w_ia  = SRC_W'(int'(w_gene[3:0]) % NSRC);
      assign w_ib  = SRC_W'(int'(w_gene[7:4]) % NSRC);
      assign w_lut = w_gene[11:8];
      assign w_out = w_lut[{w_src[w_ib], w_src[w_ia]}] ^ (^w_gene[GENE_W-1:12]);

      assign w_cell[COL*gi+gj] = w_out;
    end
  end

  for (genvar go = 0; go < OUT; go++) begin : g_out
    logic [CELL_SEL_W-1:0] w_sel;
    assign w_sel     = i_osel[CELL_SEL_W*go +: CELL_SEL_W];
    assign o_out[go] = (int'(w_sel) < NCELL) ? w_cell[w_sel] : 1'b0;
  end

endmodule

// File: rtl/chrom_serial_evaluator.sv
// Serial chromosome loader + exhaustive truth-table fitness evaluator.
// Words arrive LSB-first; after the last word the array is swept over every
// input vector (one per cycle) and the matching-bit count is offered on a
// valid/ready result port.
module chrom_serial_evaluator
  import cgp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic [LOAD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [TT_W-1:0]   target_tt,
  output logic [FIT_W-1:0]  fitness,
  output logic              perfect,
  output logic              fit_valid,
  input  logic              fit_ready,
  output logic              busy
);

  eval_state_t r_state;
  eval_state_t w_state_nx;

  logic [CHROM_W-1:0] r_chrom;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [IN-1:0]      r_vec;
  logic [FIT_W-1:0]   r_acc;
  logic [FIT_W-1:0]   r_fitness;
  logic               r_perfect;
  logic [TT_W-1:0]    r_target;

  logic               w_s_ready;
  logic               w_busy;
  logic               w_fit_valid;
  logic               w_accept;
  logic               w_last_word;
  logic               w_vec_last;
  logic [SH_W-1:0]    w_shamt;
  logic [CHROM_W-1:0] w_word_bits;
  logic [CHROM_W-1:0] w_word_mask;
  logic [CHROM_W-1:0] w_chrom_nx;
  logic [NCELL*GENE_W-1:0]   w_genes;
  logic [CELL_SEL_W*OUT-1:0] w_osel;
  logic [OUT-1:0]     w_out;
  logic [OUT-1:0]     w_tgt;
  logic [FIT_W-1:0]   w_acc_nx;

  assign w_accept    = s_valid && w_s_ready;
  assign w_last_word = (r_wcnt == WCNT_W'(NWORDS - 1));
  assign w_vec_last  = (r_vec == IN'(NVEC - 1));

  // Bits of a word that land above CHROM_W-1 are shifted out and never stored.
  assign w_shamt     = SH_W'(r_wcnt) * SH_W'(LOAD_W);
  assign w_word_bits = CHROM_W'(s_data) << w_shamt;
  assign w_word_mask = {{(CHROM_W-LOAD_W){1'b0}}, {LOAD_W{1'b1}}} << w_shamt;
  assign w_chrom_nx  = (r_chrom & ~w_word_mask) | (w_word_bits & w_word_mask);

  assign w_tgt    = r_target[int'(r_vec)*OUT +: OUT];
  assign w_acc_nx = r_acc + match_count(w_out, w_tgt);

  chrom_slicer u_slicer (
    .i_chrom (r_chrom),
    .o_genes (w_genes),
    .o_osel  (w_osel)
  );

  newGenetico #(
    .ROW        (ROW),
    .COL        (COL),
    .IN         (IN),
    .OUT        (OUT),
    .GENE_W     (GENE_W),
    .CELL_SEL_W (CELL_SEL_W)
  ) u_array (
    .i_in    (r_vec),
    .i_genes (w_genes),
    .i_osel  (w_osel),
    .o_out   (w_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state selection and state-decoded handshake/status outputs.
  always_comb begin
    w_state_nx  = r_state;
    w_s_ready   = 1'b0;
    w_busy      = 1'b0;
    w_fit_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_s_ready = 1'b1;
        if (s_valid) begin
          w_state_nx = w_last_word ? EVAL : LOAD;
        end else begin
          w_state_nx = IDLE;
        end
      end
      LOAD: begin
        w_s_ready = 1'b1;
        w_busy    = 1'b1;
        if (s_valid && w_last_word) begin
          w_state_nx = EVAL;
        end else begin
          w_state_nx = LOAD;
        end
      end
      EVAL: begin
        w_busy = 1'b1;
        if (w_vec_last) begin
          w_state_nx = DONE;
        end else begin
          w_state_nx = EVAL;
        end
      end
      DONE: begin
        w_fit_valid = 1'b1;
        if (fit_ready) begin
          w_state_nx = IDLE;
        end else begin
          w_state_nx = DONE;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
    if (abort) begin
      w_state_nx = IDLE;
    end else begin
      w_state_nx = w_state_nx;
    end
  end

  // Chromosome capture, vector sweep, accumulation and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chrom   <= '0;
      r_wcnt    <= '0;
      r_vec     <= '0;
      r_acc     <= '0;
      r_fitness <= '0;
      r_perfect <= 1'b0;
      r_target  <= '0;
    end else if (abort) begin
      r_chrom   <= '0;
      r_wcnt    <= '0;
      r_vec     <= '0;
      r_acc     <= '0;
      r_fitness <= '0;
      r_perfect <= 1'b0;
      r_target  <= '0;
    end else begin
      case (r_state)
        IDLE, LOAD: begin
          if (w_accept) begin
            r_chrom <= w_chrom_nx;
            if (w_last_word) begin
              r_wcnt   <= '0;
              r_target <= target_tt;
              r_acc    <= '0;
              r_vec    <= '0;
            end else begin
              r_wcnt <= r_wcnt + WCNT_W'(1);
            end
          end
        end
        EVAL: begin
          r_acc <= w_acc_nx;
          r_vec <= r_vec + IN'(1);
          if (w_vec_last) begin
            r_fitness <= w_acc_nx;
            r_perfect <= (w_acc_nx == FIT_W'(TT_W));
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s_ready   = w_s_ready;
  assign busy      = w_busy;
  assign fit_valid = w_fit_valid;
  assign fitness   = r_fitness;
  assign perfect   = r_perfect;

endmodule
